imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into instruction memory. It checks a trailing XOR checksum and holds the CPU in reset until a load completes cleanly.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   localparam int unsigned BYTE_IDX_W          = 2;
   localparam int unsigned DEPTH_WORDS_DEFAULT = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four stream bytes, LSB first, into one 32-bit little-endian word.
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic        word_ready_c,
   output logic [31:0] word_c
);

   logic [BYTE_IDX_W-1:0] byte_idx;
   logic [31:0]           asm_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_idx <= '0;
         asm_q    <= '0;
      end else if (clear) begin
         byte_idx <= '0;
         asm_q    <= '0;
      end else if (accept) begin
         asm_q[{byte_idx, 3'b000} +: 8] <= data;
         byte_idx                       <= byte_idx + BYTE_IDX_W'(1);
      end
   end

   // The fourth byte bypasses the register so the word is ready on its accept edge.
   assign word_ready_c = accept && (byte_idx == '1);
   assign word_c       = {data, asm_q[23:0]};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes words to instruction memory, checks an XOR
// trailer and holds the CPU in reset until a clean load completes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
   parameter int unsigned ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              bad_count;
   logic              last_word;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] n_last;
   logic [7:0]        xacc;
   logic              word_ready_c;
   logic [31:0]       word_c;
   logic              ready_dec;
   logic              done_d;
   logic              err_d;
   logic              cpu_rst_d;

   assign accept    = in_valid && in_ready;
   assign bad_count = (in_data == 8'd0) || (32'(in_data) > DEPTH_WORDS);
   assign last_word = (word_idx == n_last);

   word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear        ((state == S_COUNT) && accept),
      .accept       ((state == S_DATA) && accept),
      .data         (in_data),
      .word_ready_c (word_ready_c),
      .word_c       (word_c)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_COUNT;
         S_COUNT: if (accept) state_nxt = bad_count ? S_ERROR : S_DATA;
         S_DATA:  if (word_ready_c && last_word) state_nxt = S_CHECK;
         S_CHECK: if (accept) state_nxt = (in_data == xacc) ? S_DONE : S_ERROR;
         S_DONE:  if (start) state_nxt = S_COUNT;
         S_ERROR: if (start) state_nxt = S_COUNT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ready_dec = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cpu_rst_d = 1'b1;
      case (state)
         S_COUNT, S_DATA, S_CHECK: ready_dec = 1'b1;
         S_DONE: begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
         end
         S_ERROR: err_d = 1'b1;
         default: ;
      endcase
   end

   // in_ready depends on state alone so the source never sees a valid-to-ready path.
   assign in_ready = ready_dec;

   always_ff @(posedge clk) begin
      if (!rst) begin
         done    <= 1'b0;
         err     <= 1'b0;
         cpu_rst <= 1'b1;
      end else begin
         done    <= done_d;
         err     <= err_d;
         cpu_rst <= cpu_rst_d;
      end
   end

   // Write registers are separate from the assembler, so intake never stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         word_idx  <= '0;
         n_last    <= '0;
         xacc      <= '0;
      end else begin
         mem_we <= word_ready_c;
         if ((state == S_COUNT) && accept) begin
            n_last   <= ADDR_W'(in_data - 8'd1);
            word_idx <= '0;
            xacc     <= '0;
         end
         if ((state == S_DATA) && accept) xacc <= xacc ^ in_data;
         if (word_ready_c) begin
            mem_addr  <= word_idx;
            mem_wdata <= word_c;
            word_idx  <= word_idx + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] shadow [DEPTH];
   wq_t         wr_addr_q;
   wq_t         wr_data_q;

   imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Instruction memory stand-in plus write log.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(32'(mem_addr));
         wr_data_q.push_back(mem_wdata);
         shadow[mem_addr] = mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: what a correct loader must do with a whole stream.
   function automatic void model(input bq_t s, output wq_t words, output bit ok,
                                 output int n_acc);
      int         n;
      logic [7:0] x;
      words = {};
      ok    = 1'b0;
      n     = int'(s[0]);
      n_acc = 1;
      if (n == 0 || n > int'(DEPTH)) return;
      x = 8'h00;
      for (int i = 0; i < n; i++)
         words.push_back({s[4*i+4], s[4*i+3], s[4*i+2], s[4*i+1]});
      for (int i = 1; i <= 4*n; i++) x ^= s[i];
      ok    = (s[4*n+1] == x);
      n_acc = 4*n + 2;
   endfunction

   function automatic bq_t make_stream(input int n, input bit corrupt);
      bq_t        s;
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      s.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         x ^= b;
         s.push_back(b);
      end
      s.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
      return s;
   endfunction

   function automatic bq_t nominal(input logic [7:0] trailer);
      bq_t s;
      s = '{8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      s.push_back(trailer);
      return s;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offers each byte after a random idle gap; stops if a byte is never taken.
   task automatic send_bytes(input bq_t s, input int max_gap, output int sent);
      int budget;
      sent = 0;
      foreach (s[k]) begin
         repeat ($urandom_range(0, max_gap)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = s[k];
         budget   = 0;
         forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 40) break;
            @(posedge clk); #1;
         end
         if (budget > 40) break;
         @(posedge clk); #1;
         sent++;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic run_load(input string tag, input bq_t s, input int max_gap);
      wq_t words;
      bit  ok;
      int  n_acc;
      int  sent;
      model(s, words, ok, n_acc);
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      send_bytes(s, max_gap, sent);
      chk({tag, "_accepted"}, 32'(sent), 32'(n_acc));
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done"},    {31'd0, done},     {31'd0, ok});
      chk({tag, "_err"},     {31'd0, err},      {31'd0, !ok});
      chk({tag, "_cpu_rst"}, {31'd0, cpu_rst},  {31'd0, !ok});
      chk({tag, "_ready"},   {31'd0, in_ready}, 32'd0);
      chk({tag, "_nwrites"}, 32'(wr_data_q.size()), 32'(words.size()));
      foreach (words[i]) begin
         if (i < wr_data_q.size()) begin
            chk({tag, "_addr"}, wr_addr_q[i], 32'(i));
            chk({tag, "_data"}, wr_data_q[i], words[i]);
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"},   {31'd0, in_ready}, 32'd0);
      chk({tag, "_we"},      {31'd0, mem_we},   32'd0);
      chk({tag, "_addr"},    32'(mem_addr),     32'd0);
      chk({tag, "_wdata"},   mem_wdata,         32'd0);
      chk({tag, "_cpu_rst"}, {31'd0, cpu_rst},  32'd1);
      chk({tag, "_done"},    {31'd0, done},     32'd0);
      chk({tag, "_err"},     {31'd0, err},      32'd0);
   endtask

   initial begin
      bq_t s;
      int  sent;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      run_load("nominal", nominal(8'hB0), 0);
      chk("nominal_w0", shadow[0], 32'h00100513);
      chk("nominal_w1", shadow[1], 32'h00200593);
      run_load("badsum", nominal(8'hB1), 0);
      run_load("cnt00", '{8'h00}, 0);
      run_load("cnt21", '{8'h21}, 0);
      for (int r = 0; r < 3; r++) run_load("gaps", nominal(8'hB0), 5);

      run_load("n1", make_stream(1, 1'b0), 2);
      run_load("n32", make_stream(32, 1'b0), 0);
      for (int r = 0; r < 10; r++)
         run_load("rand", make_stream($urandom_range(1, 6), ($urandom_range(0, 3) == 0)),
                  $urandom_range(0, 3));

      // Abandon a load after word 0 has been written.
      shadow[0] = 32'hDEADBEEF;
      s = nominal(8'hB0);
      s = s[0:6];
      pulse_start();
      send_bytes(s, 0, sent);
      chk("midrst_sent", 32'(sent), 32'd7);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset("midrst");
      rst = 1'b1;
      chk("midrst_w0", shadow[0], 32'h00100513);
      @(posedge clk); #1;
      run_load("after_rst", nominal(8'hB0), 1);

      // Restart from DONE.
      pulse_start();
      chk("restart_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("restart_done",    {31'd0, done},    32'd0);
      chk("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      run_load("restart_load", nominal(8'hB0), 0);

      // start pulsed while payload is streaming must be ignored.
      fork
         run_load("start_in_data", nominal(8'hB0), 0);
         begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      join

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
